// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler that feeds a toggle/XOR pulse synchronizer.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Smallest legal pulse spacing; one cycle of ISSUE plus at least one cycle of GAP.
  localparam int GAP_MIN = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arb.sv
// Combinational round-robin pick: first set bit of i_pend at or after i_ptr, wrapping modulo NREQ.
module pulse_sched_rr_arb
  import pulse_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_vld
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_vld && i_pend[j]) begin
        o_vld    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler that serialises request events onto one pulse-synchronizer channel,
// holding off each pulse until GAP cycles after the previous one so toggles never merge.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int GAP  = 6,
  localparam int IDXW = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            clr_ovf,
  output logic            pulse_o,
  output logic [IDXW-1:0] sel_o,
  output logic [NREQ-1:0] ack_o,
  output logic [NREQ-1:0] pend_o,
  output logic            busy_o,
  output logic [NREQ-1:0] ovf_o
);

  localparam int CW = $clog2(GAP + 1);

  if (GAP < GAP_MIN || NREQ < 2 || NREQ > 16) begin : g_bad_param
    $error("pulse_sched: GAP must be >= 2 and NREQ within 2..16");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_ovf;
  logic [NREQ-1:0] r_ack;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_sel;
  logic            r_pulse;
  logic [CW-1:0]   r_gap_cnt;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IDXW-1:0] w_idx;
  logic            w_vld;
  logic            w_issue;
  logic [NREQ-1:0] w_clr;
  logic [IDXW-1:0] w_ptr_nxt;

  pulse_sched_rr_arb #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_idx),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vld) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_GAP;
      ST_GAP: begin
        // Last GAP cycle: issue straight away so saturated spacing is exactly GAP.
        if (r_gap_cnt == CW'(1)) begin
          if (w_vld) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr     = w_issue ? w_arb_gnt : '0;
  assign w_ptr_nxt = (w_idx == IDXW'(NREQ - 1)) ? '0 : w_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A new event on the bit being granted re-arms it; otherwise a repeat is merged and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | req;
      r_ovf  <= (clr_ovf ? '0 : r_ovf) | (req & r_pend & ~w_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse   <= 1'b0;
      r_ack     <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_pulse <= w_issue;
      r_ack   <= w_clr;
      if (w_issue) begin
        r_sel     <= w_idx;
        r_ptr     <= w_ptr_nxt;
        r_gap_cnt <= CW'(GAP - 1);
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt - CW'(1);
      end
    end
  end

  assign pulse_o = r_pulse;
  assign sel_o   = r_sel;
  assign ack_o   = r_ack;
  assign pend_o  = r_pend;
  assign ovf_o   = r_ovf;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched plus an end-to-end run through a toggle synchronizer model.
module tb_pulse_sched;

  localparam int NREQ = 4;
  localparam int GAP  = 6;
  localparam int GAP7 = 7;

  logic       clk = 1'b0;
  logic       clkb = 1'b0;
  logic       rst = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       clr7 = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req7 = '0;

  logic       pulse_o, busy_o;
  logic [1:0] sel_o;
  logic [3:0] ack_o, pend_o, ovf_o;
  logic       pulse7, busy7;
  logic [1:0] sel7;
  logic [3:0] ack7, pend7, ovf7;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #10 clkb = ~clkb;
  end

  pulse_sched #(.NREQ(NREQ), .GAP(GAP)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .clr_ovf (clr_ovf),
    .pulse_o (pulse_o),
    .sel_o   (sel_o),
    .ack_o   (ack_o),
    .pend_o  (pend_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o)
  );

  pulse_sched #(.NREQ(NREQ), .GAP(GAP7)) u_dut7 (
    .clk     (clk),
    .rst     (rst),
    .req     (req7),
    .clr_ovf (clr7),
    .pulse_o (pulse7),
    .sel_o   (sel7),
    .ack_o   (ack7),
    .pend_o  (pend7),
    .busy_o  (busy7),
    .ovf_o   (ovf7)
  );

  // Toggle/XOR synchronizer model with a destination clock at half the source rate.
  logic tgl = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   n_ack7 = 0, n_outb = 0, n_cyc = 0, last_pulse = -100, n_space_err = 0;

  always @(posedge clk) begin
    n_cyc <= n_cyc + 1;
    if (pulse7) begin
      tgl        <= ~tgl;
      last_pulse <= n_cyc;
      if (n_cyc - last_pulse < GAP7) n_space_err <= n_space_err + 1;
    end
    if (|ack7) n_ack7 <= n_ack7 + 1;
  end

  always @(posedge clkb) begin
    s1 <= tgl;
    s2 <= s1;
    s3 <= s2;
    if (s2 ^ s3) n_outb <= n_outb + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    req7    = '0;
    clr_ovf = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, 32'(pulse_o), 32'd0);
    chk({tag, "_ack"},   32'(ack_o),   32'd0);
    chk({tag, "_sel"},   32'(sel_o),   32'd0);
    chk({tag, "_pend"},  32'(pend_o),  32'd0);
    chk({tag, "_ovf"},   32'(ovf_o),   32'd0);
    chk({tag, "_busy"},  32'(busy_o),  32'd0);
  endtask

  initial begin
    int np;
    int g;

    do_reset();
    chk_all_zero("rst");

    // Single request: pending one edge later, pulse one edge after that.
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    chk("t1_pend",  32'(pend_o),  32'h4);
    chk("t1_idle",  32'(pulse_o), 32'd0);
    tick();
    chk("t1_pulse", 32'(pulse_o), 32'd1);
    chk("t1_ack",   32'(ack_o),   32'h4);
    chk("t1_sel",   32'(sel_o),   32'd2);
    chk("t1_pend0", 32'(pend_o),  32'd0);
    chk("t1_busy",  32'(busy_o),  32'd1);
    tick();
    chk("t1_pulse_off", 32'(pulse_o), 32'd0);
    chk("t1_ack_off",   32'(ack_o),   32'd0);
    chk("t1_sel_hold",  32'(sel_o),   32'd2);

    // All four requesters at once: grants 0..3 exactly GAP apart.
    do_reset();
    req = 4'hF;
    tick();
    req = '0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 1 || k == 7 || k == 13 || k == 19) begin
        g = (k - 1) / 6;
        chk("t2_pulse", 32'(pulse_o), 32'd1);
        chk("t2_ack",   32'(ack_o),   32'(1 << g));
        chk("t2_sel",   32'(sel_o),   32'(g));
      end else begin
        chk("t2_nopulse", 32'(pulse_o), 32'd0);
      end
      if (k == 24) chk("t2_busy_hi", 32'(busy_o), 32'd1);
      if (k == 25) chk("t2_busy_lo", 32'(busy_o), 32'd0);
    end
    chk("t2_sel_idle", 32'(sel_o), 32'd3);

    // Overflow on a repeated pending request, then clear/overflow collision.
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    chk("t3_ack0", 32'(ack_o), 32'h1);
    req = 4'b0010;
    tick();
    req = '0;
    chk("t3_ovf",  32'(ovf_o),  32'h2);
    chk("t3_pend", 32'(pend_o), 32'h2);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("t3_gap_nopulse", 32'(pulse_o), 32'd0);
    end
    tick();
    chk("t3_pulse1", 32'(pulse_o), 32'd1);
    chk("t3_ack1",   32'(ack_o),   32'h2);
    chk("t3_sel1",   32'(sel_o),   32'd1);
    req = 4'b0100;
    tick();
    req     = 4'b0100;
    clr_ovf = 1'b1;
    tick();
    req = '0;
    chk("t3_ovf_wins", 32'(ovf_o), 32'h4);
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(ovf_o), 32'd0);

    // New request on the bit being granted in the same edge re-arms it without overflow.
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    chk("t4_pulse", 32'(pulse_o), 32'd1);
    chk("t4_ack",   32'(ack_o),   32'h8);
    chk("t4_pend",  32'(pend_o),  32'h8);
    chk("t4_ovf",   32'(ovf_o),   32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t4_gap_nopulse", 32'(pulse_o), 32'd0);
    end
    tick();
    chk("t4_regrant", 32'(pulse_o), 32'd1);
    chk("t4_ack2",    32'(ack_o),   32'h8);
    chk("t4_sel",     32'(sel_o),   32'd3);
    chk("t4_pend0",   32'(pend_o),  32'd0);
    chk("t4_ovf2",    32'(ovf_o),   32'd0);

    // Reset in the middle of a GAP with events pending discards everything.
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    req = 4'b0110;
    tick();
    req = '0;
    tick();
    chk("t5_pend_pre", 32'(pend_o), 32'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t5");
    np = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pulse_o) np++;
    end
    chk("t5_no_pulse", 32'(np), 32'd0);

    // Random traffic through the synchronizer model: every grant reaches the destination.
    for (int k = 0; k < 3000; k++) begin
      req7 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tick();
    end
    req7 = '0;
    for (int k = 0; k < 200; k++) tick();
    chk("t6_any_grants", 32'(n_ack7 > 50), 32'd1);
    chk("t6_outb_eq_ack", 32'(n_outb), 32'(n_ack7));
    chk("t6_spacing", 32'(n_space_err), 32'd0);
    chk("t6_drained", 32'(pend7), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
